// File: rtl/branch_pkg.sv
// Shared branch encodings, 2-bit counter states and the BTB entry layout.
// Latency: n/a (types only). Backpressure: n/a.
package branch_pkg;

    localparam int BR_TYPE_W = 3;

    localparam logic [BR_TYPE_W-1:0] NOBRANCH = 3'd0;
    localparam logic [BR_TYPE_W-1:0] BEQ      = 3'd1;
    localparam logic [BR_TYPE_W-1:0] BNE      = 3'd2;
    localparam logic [BR_TYPE_W-1:0] BLT      = 3'd3;
    localparam logic [BR_TYPE_W-1:0] BLTU     = 3'd4;
    localparam logic [BR_TYPE_W-1:0] BGE      = 3'd5;
    localparam logic [BR_TYPE_W-1:0] BGEU     = 3'd6;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Fields are sized for the widest supported PC; narrower builds use the low bits.
    localparam int BTB_TAG_W = 30;
    localparam int BTB_TGT_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        logic [1:0]           ctr;
    } btb_entry_t;

    function automatic logic is_cond_branch(input logic [BR_TYPE_W-1:0] br_type);
        return (br_type >= BEQ) && (br_type <= BGEU);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch compare: resolves BEQ..BGEU on two operands.
// Latency: combinational. Backpressure: none.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [BR_TYPE_W-1:0] br_type,
    input  logic [XLEN-1:0]      op1,
    input  logic [XLEN-1:0]      op2,
    output logic                 taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BEQ:     taken = (op1 == op2);
            BNE:     taken = (op1 != op2);
            BLT:     taken = ($signed(op1) <  $signed(op2));
            BLTU:    taken = (op1 <  op2);
            BGE:     taken = ($signed(op1) >= $signed(op2));
            BGEU:    taken = (op1 >= op2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// BTB/2-bit predictor for IF plus EX branch resolution, redirect and training.
// Latency: lookup/resolve combinational; table and counters update on the next edge.
// Backpressure: StallE (or !ValidE) suppresses training and counting; outputs still follow inputs.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter bit PRED_EN = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      PCF,
    output logic                 PredTakenF,
    output logic [XLEN-1:0]      PredTargetF,
    input  logic                 ValidE,
    input  logic                 StallE,
    input  logic [BR_TYPE_W-1:0] BranchTypeE,
    input  logic [XLEN-1:0]      Operand1E,
    input  logic [XLEN-1:0]      Operand2E,
    input  logic [XLEN-1:0]      PCE,
    input  logic [XLEN-1:0]      BrTargetE,
    input  logic                 PredTakenE,
    input  logic [XLEN-1:0]      PredTargetE,
    output logic                 BranchE,
    output logic                 MispredictE,
    output logic [XLEN-1:0]      RedirectPCE,
    output logic [CNT_W-1:0]     BranchCnt,
    output logic [CNT_W-1:0]     MispredCnt
);

    localparam int              IDX_W = $clog2(ENTRIES);
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    btb_entry_t tbl_q [ENTRIES];

    logic [IDX_W-1:0]     idx_f, idx_e;
    logic [BTB_TAG_W-1:0] tag_f, tag_e;
    btb_entry_t           ent_f, ent_e, wr_dat;
    logic                 hit_f, tagm_e, hit_e, is_br, upd_en, wr_en;
    logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_f = BTB_TAG_W'(PCF[XLEN-1:IDX_W+2]);
    assign tag_e = BTB_TAG_W'(PCE[XLEN-1:IDX_W+2]);
    assign ent_f = tbl_q[idx_f];
    assign ent_e = tbl_q[idx_e];

    assign hit_f       = ent_f.valid && (ent_f.tag == tag_f);
    assign PredTakenF  = PRED_EN && hit_f && ent_f.ctr[1];
    assign PredTargetF = PredTakenF ? ent_f.target[XLEN-1:0] : PCF + PC_INC;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .br_type (BranchTypeE),
        .op1     (Operand1E),
        .op2     (Operand2E),
        .taken   (BranchE)
    );

    assign is_br  = ValidE && is_cond_branch(BranchTypeE);
    assign tagm_e = (ent_e.tag == tag_e);
    assign hit_e  = ent_e.valid && tagm_e;
    assign upd_en = ValidE && !StallE;

    // Second term catches a stale/aliased entry that predicted taken on a non-branch.
    assign MispredictE = (is_br && ((BranchE != PredTakenE) ||
                                    (BranchE && (PredTargetE != BrTargetE))))
                       || (ValidE && !is_br && PredTakenE);
    assign RedirectPCE = (is_br && BranchE) ? BrTargetE : PCE + PC_INC;

    always_comb begin
        wr_en  = 1'b0;
        wr_dat = ent_e;
        if (PRED_EN && upd_en) begin
            if (is_br && hit_e) begin
                wr_en = 1'b1;
                if (BranchE) begin
                    wr_dat.ctr    = (ent_e.ctr == ST) ? ST : ent_e.ctr + 2'd1;
                    wr_dat.target = BTB_TGT_W'(BrTargetE);
                end else begin
                    wr_dat.ctr    = (ent_e.ctr == SNT) ? SNT : ent_e.ctr - 2'd1;
                end
            end else if (is_br && BranchE) begin
                wr_en         = 1'b1;
                wr_dat.valid  = 1'b1;
                wr_dat.tag    = tag_e;
                wr_dat.target = BTB_TGT_W'(BrTargetE);
                wr_dat.ctr    = WT;
            end else if (!is_br && ValidE && PredTakenE && tagm_e) begin
                wr_en        = 1'b1;
                wr_dat.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (wr_en) begin
            tbl_q[idx_e] <= wr_dat;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en) begin
            if (is_br)       branch_cnt_d  = branch_cnt_q + CNT_W'(1);
            if (MispredictE) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve (dynamic build plus a PRED_EN=0 build on shared inputs).
module tb_branch_predict_resolve;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, Operand1E, Operand2E, PCE, BrTargetE, PredTargetE;
    logic        ValidE, StallE, PredTakenE;
    logic [2:0]  BranchTypeE;

    logic        PredTakenF, BranchE, MispredictE;
    logic [31:0] PredTargetF, RedirectPCE, BranchCnt, MispredCnt;
    logic        s_PredTakenF, s_BranchE, s_MispredictE;
    logic [31:0] s_PredTargetF, s_RedirectPCE, s_BranchCnt, s_MispredCnt;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .ValidE(ValidE), .StallE(StallE), .BranchTypeE(BranchTypeE),
        .Operand1E(Operand1E), .Operand2E(Operand2E), .PCE(PCE), .BrTargetE(BrTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .BranchE(BranchE),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    branch_predict_resolve #(.PRED_EN(1'b0)) dut_static (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(s_PredTakenF), .PredTargetF(s_PredTargetF),
        .ValidE(ValidE), .StallE(StallE), .BranchTypeE(BranchTypeE),
        .Operand1E(Operand1E), .Operand2E(Operand2E), .PCE(PCE), .BrTargetE(BrTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .BranchE(s_BranchE),
        .MispredictE(s_MispredictE), .RedirectPCE(s_RedirectPCE),
        .BranchCnt(s_BranchCnt), .MispredCnt(s_MispredCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt, input logic vld);
        BranchTypeE = t; Operand1E = a; Operand2E = b; PCE = pc; BrTargetE = tgt;
        PredTakenE = pt; PredTargetE = ptgt; ValidE = vld;
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ValidE = 1'b0; StallE = 1'b0; BranchTypeE = NOBRANCH; PredTakenE = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_tgt);
        PCF = pc; #1;
        chk({tag, "_taken"}, {31'd0, PredTakenF}, {31'd0, exp_t});
        chk({tag, "_target"}, PredTargetF, exp_tgt);
        chk({tag, "_static_taken"}, {31'd0, s_PredTakenF}, 32'd0);
    endtask

    task automatic cnts(input string tag, input logic [31:0] eb, input logic [31:0] em);
        chk({tag, "_brcnt"}, BranchCnt, eb);
        chk({tag, "_mpcnt"}, MispredCnt, em);
    endtask

    task automatic res(input string tag, input logic eb, input logic em, input logic [31:0] erd);
        #1;
        chk({tag, "_BranchE"}, {31'd0, BranchE}, {31'd0, eb});
        chk({tag, "_Mispred"}, {31'd0, MispredictE}, {31'd0, em});
        chk({tag, "_Redirect"}, RedirectPCE, erd);
    endtask

    initial begin
        rst_n = 1'b0; PCF = 32'h100; Operand1E = '0; Operand2E = '0; PCE = '0;
        BrTargetE = '0; PredTargetE = '0;
        idle();
        #2;
        look("rst", 32'h100, 1'b0, 32'h104);
        cnts("rst", 0, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Allocate at 0x100; same-cycle lookup still sees the old (empty) entry.
        ex(BGE, 5, 5, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1);
        res("alloc", 1'b1, 1'b1, 32'h80);
        look("alloc_coll", 32'h100, 1'b0, 32'h104);
        tick(); idle();
        look("alloc_hit", 32'h100, 1'b1, 32'h80);
        cnts("alloc", 1, 1);

        // Three correct taken resolutions: ctr 10 -> 11 and saturates.
        for (int i = 0; i < 3; i++) begin
            ex(BEQ, 3, 3, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1);
            res("train", 1'b1, 1'b0, 32'h80);
            tick();
        end
        idle();
        cnts("train", 4, 1);

        // Unsigned 0xFFFFFFFF < 1 is false: not-taken mispredict, ctr 11 -> 10.
        ex(BLTU, 32'hFFFF_FFFF, 1, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1);
        res("bltu_nt", 1'b0, 1'b1, 32'h104);
        tick(); idle();
        look("after_nt", 32'h100, 1'b1, 32'h80);
        cnts("after_nt", 5, 2);

        // Compare coverage with ValidE=0: BranchE ungated, nothing mispredicts.
        ex(BLT, 32'hFFFF_FFFF, 1, 32'h100, 32'h80, 1'b1, 32'h80, 1'b0);
        res("blt_inv", 1'b1, 1'b0, 32'h104);
        ex(BGEU, 7, 7, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0);
        res("bgeu_eq", 1'b1, 1'b0, 32'h104);
        ex(BGE, 32'hFFFF_FFFE, 1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0);
        res("bge_neg", 1'b0, 1'b0, 32'h104);
        ex(BNE, 9, 9, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0);
        res("bne_eq", 1'b0, 1'b0, 32'h104);
        ex(3'd7, 1, 1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0);
        res("undef", 1'b0, 1'b0, 32'h104);
        idle(); tick();
        cnts("inv", 5, 2);

        // 0x200 aliases 0x100's index with a different tag and evicts it.
        ex(BNE, 1, 2, 32'h200, 32'h300, 1'b0, 32'h0, 1'b1);
        res("alias", 1'b1, 1'b1, 32'h300);
        tick(); idle();
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 32'h300);
        cnts("alias", 6, 3);

        // Stalled resolution with a new target: no update until release.
        ex(BEQ, 7, 7, 32'h200, 32'h340, 1'b1, 32'h300, 1'b1);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res("stall", 1'b1, 1'b1, 32'h340);
            tick();
            look("stall_tbl", 32'h200, 1'b1, 32'h300);
            cnts("stall", 6, 3);
        end
        StallE = 1'b0;
        tick(); idle();
        look("release", 32'h200, 1'b1, 32'h340);
        cnts("release", 7, 4);

        // Non-branch predicted taken: redirect to PC+4 and drop the entry.
        ex(NOBRANCH, 0, 0, 32'h200, 32'h0, 1'b1, 32'h340, 1'b1);
        res("nonbr", 1'b0, 1'b1, 32'h204);
        tick(); idle();
        look("nonbr_inv", 32'h200, 1'b0, 32'h204);
        cnts("nonbr", 7, 5);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Async reset in the middle of a pending update.
        ex(BGE, 5, 5, 32'h100, 32'h80, 1'b0, 32'h0, 1'b1);
        tick();
        look("pre_rst", 32'h100, 1'b1, 32'h80);
        ex(BGE, 5, 5, 32'h200, 32'h90, 1'b0, 32'h0, 1'b1);
        #1 rst_n = 1'b0;
        look("mid_rst", 32'h100, 1'b0, 32'h104);
        cnts("mid_rst", 0, 0);
        tick();
        look("rst_edge", 32'h200, 1'b0, 32'h204);
        cnts("rst_edge", 0, 0);
        idle();
        @(negedge clk); rst_n = 1'b1;
        tick();
        look("post_rst", 32'h100, 1'b0, 32'h104);
        chk("static_brcnt", s_BranchCnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
Combined branch predictor and branch resolution unit for the RV32 pipeline.
- IF stage: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters supplies a predicted direction and target for the fetch PC.
- EX stage: resolves the conditional branch (BEQ/BNE/BLT/BLTU/BGE/BGEU), flags mispredictions, produces the redirect PC, and trains the table on the clock edge.
- Replaces the purely combinational branch decision in EX; the hazard unit consumes MispredictE for flush/redirect.

Parameters:
XLEN, 32, operand and PC width
ENTRIES, 64, BTB/BHT entry count; power of two, >=2
IDX_W, log2(ENTRIES), index width (derived, not overridden)
PRED_EN, 1, 1 = dynamic prediction; 0 = static not-taken (table frozen, PredTakenF=0)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
PCF  in  XLEN  fetch PC
PredTakenF  out  1  predicted taken for PCF
PredTargetF  out  XLEN  predicted next PC (target if taken, else PCF+4)
ValidE  in  1  EX holds a real (unflushed) instruction
StallE  in  1  EX stage stalled this cycle
BranchTypeE  in  3  branch type code (shared package)
Operand1E, Operand2E  in  XLEN  rs1/rs2 values after forwarding
PCE  in  XLEN  PC of EX instruction
BrTargetE  in  XLEN  computed branch target
PredTakenE, PredTargetE  in  1, XLEN  prediction piped from IF
BranchE  out  1  actual branch outcome
MispredictE  out  1  redirect required
RedirectPCE  out  XLEN  correct next PC
BranchCnt, MispredCnt  out  CNT_W  performance counters

Behaviour:
- Indexing: idx = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]. Entry = {valid, tag, target, ctr[1:0]}.
- Lookup (combinational from registered table):
  - hit = valid && tag match.
  - PredTakenF = PRED_EN && hit && ctr[1].
  - PredTargetF = PredTakenF ? target : PCF+4 (wraps mod 2^XLEN).
- Condition (combinational): BEQ ==, BNE !=, BLT signed <, BLTU unsigned <, BGE signed >=, BGEU unsigned >=, NOBRANCH/undefined codes -> 0. BGE/BGEU include equality.
- BranchE = condition result; it is not gated by ValidE.
- isBr = ValidE && BranchTypeE in {BEQ..BGEU}.
- MispredictE = (isBr && (BranchE != PredTakenE || (BranchE && PredTargetE != BrTargetE))) || (ValidE && !isBr && PredTakenE).
  - The second term covers an aliased false hit on a non-branch.
  - MispredictE is not gated by StallE; the hazard unit owns that.
- RedirectPCE = (isBr && BranchE) ? BrTargetE : PCE+4.
- Update on posedge clk, only when ValidE && !StallE:
  - isBr and hit at PCE: ctr saturating increment if BranchE, else decrement (00 and 11 hold). If BranchE, target <= BrTargetE.
  - isBr, miss, BranchE: allocate valid=1, tag, target=BrTargetE, ctr=10. Any victim is overwritten.
  - isBr, miss, not taken: no change.
  - !isBr && PredTakenE and tag match at PCE: valid <= 0.
  - PRED_EN=0: no table writes.
- Read/write collision (same idx looked up in IF while EX writes): IF sees the old value; the new value is visible next cycle.
- Perf counters update under the same gating (ValidE && !StallE):
  - BranchCnt++ on isBr.
  - MispredCnt++ on MispredictE.
  - Both wrap at 2^CNT_W.
- Reset (rst_n=0, async, any cycle including mid-update): all valid=0, all ctr=01, BranchCnt=MispredCnt=0.
  - Combinational outputs follow: PredTakenF=0, PredTargetF=PCF+4.
  - No write completes on an edge where rst_n=0.

Decomposition:
- Shared package branch_pkg holds:
  - BR_TYPE_W=3.
  - Codes NOBRANCH=0, BEQ=1, BNE=2, BLT=3, BLTU=4, BGE=5, BGEU=6.
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - The entry struct typedef.
- One natural sub-module, branch_cond: purely combinational compare of BranchTypeE/Operand1E/Operand2E -> taken. It is reusable by a future second EX port.

Test Plan:
- Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104. Counters 0.
- BGE at PCE=0x100 with Op1=Op2=5, PredTakenE=0, BrTargetE=0x80 -> BranchE=1, MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80. MispredCnt=1.
- Train 0x100 taken three times, then resolve not-taken once (Op1=-1 signed, Op2=1, BLTU; PredTakenE=1) -> BranchE=0, MispredictE=1, RedirectPCE=0x104. ctr 11->10, so the next lookup still predicts taken.
- ENTRIES=64: allocate 0x100, then taken branch at 0x200 (same idx, different tag) -> 0x100 misses (PredTakenF=0), 0x200 hits.
- StallE=1 held 3 cycles on a resolving taken branch -> single table update, BranchCnt +1 only after release. Assert rst_n low mid-sequence -> all lookups miss, counters 0.
- Non-branch at 0x100 with PredTakenE=1 -> MispredictE=1, RedirectPCE=0x104, entry invalidated. PRED_EN=0 build: PredTakenF stays 0 throughout.
